main_ram_ctrl: RTL and testbench
================================

MAIN_RAM_CTRL -- requirements
Module: main_ram_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 20, address width in bits.
REQ-003 SHALL have parameter RD_WAIT, default 2, cycles _ram_cs/_ram_oe are held low per read (legal range 1..15).
REQ-004 SHALL have parameters WR_SETUP=1, WR_PULSE=2, WR_HOLD=1: write phase lengths in cycles (each legal range 1..15).
REQ-005 SHALL have port: clk  in  1  sole clock, rising-edge.
REQ-006 SHALL have port: _reset  in  1  reset; one clock; reset is synchronous and active-low.
REQ-007 SHALL have port: req_valid  in  1  host request present.
REQ-008 SHALL have port: req_ready  out  1  controller can accept a request.
REQ-009 SHALL have port: req_write  in  1  1=write, 0=read.
REQ-010 SHALL have port: req_addr  in  ADDR_WIDTH  request address.
REQ-011 SHALL have port: req_wdata  in  WIDTH  write data.
REQ-012 SHALL have port: rsp_valid  out  1  one-cycle completion pulse (read data valid, or write done).
REQ-013 SHALL have port: rsp_rdata  out  WIDTH  captured read data.
REQ-014 SHALL have ports to the async SRAM: _ram_cs, _ram_oe, _ram_w (out, 1, active-low), ram_addr (out, ADDR_WIDTH), ram_wdata (out, WIDTH), ram_rdata (in, WIDTH).

Function
REQ-015 SHALL implement FSM states IDLE, RD_ACTIVE, WR_SETUP, WR_PULSE, WR_HOLD; all outputs registered.
REQ-016 SHALL assert req_ready only in IDLE; a request is accepted on a rising edge with req_valid && req_ready.
REQ-017 SHALL latch req_addr into ram_addr and req_wdata into ram_wdata on accept and hold both unchanged until the transaction ends.
REQ-018 Read: after the accept edge, _ram_cs=0 and _ram_oe=0 for exactly RD_WAIT cycles (RD_ACTIVE); on the final edge ram_rdata is captured into rsp_rdata, _ram_cs/_ram_oe return to 1, FSM returns to IDLE.
REQ-019 Write: after accept, _ram_cs=0 for WR_SETUP+WR_PULSE+WR_HOLD cycles; _ram_w=1 during WR_SETUP, 0 during WR_PULSE, 1 during WR_HOLD; then _ram_cs=1 and IDLE.
REQ-020 SHALL hold _ram_oe=1 throughout every write; _ram_oe and _ram_w SHALL never be low in the same cycle.
REQ-021 SHALL assert rsp_valid for exactly one cycle, in the cycle following the final transaction edge; rsp_rdata SHALL hold its value until the next read completes (unchanged by writes).
REQ-022 SHALL permit accepting a new request in the same cycle rsp_valid is high (back-to-back, one IDLE cycle between transactions).
REQ-023 Phase counter SHALL be 4 bits, load (phase length - 1) on each phase entry and decrement to 0; no wrap.
REQ-024 With req_valid low in IDLE, SRAM controls SHALL stay deasserted and ram_addr/ram_wdata SHALL hold last values.

Reset
REQ-025 On a rising edge with _reset=0: FSM=IDLE, _ram_cs=_ram_oe=_ram_w=1, req_ready=0, rsp_valid=0, rsp_rdata=0, ram_addr=0, ram_wdata=0, counter=0.
REQ-026 req_ready SHALL go to 1 on the first edge with _reset=1.
REQ-027 Reset mid-transaction SHALL abort it: controls deasserted on that edge, no rsp_valid for the aborted request; a write aborted during WR_PULSE ends its _ram_w pulse on that edge.

Structure
REQ-028 Package main_ram_ctrl_pkg SHALL hold the state encoding and default timing constants.
REQ-029 One sub-module ram_phase_timer (load/decrement/zero flag) is natural; all else in main_ram_ctrl.

Verification
REQ-030 Reset then idle 5 cycles -> all SRAM controls 1, req_ready=1, rsp_valid never 1.
REQ-031 Write 0x5A to 0x00123, then read 0x00123 against behavioural async SRAM model -> _ram_w low exactly 2 cycles, rsp_valid pulse 4 cycles after write accept; read rsp_rdata=0x5A, rsp_valid 2 cycles after read accept.
REQ-032 Back-to-back writes 0x11@0x001, 0x22@0x002, req_valid held high -> second accepted in cycle of first rsp_valid; readback 0x11, 0x22.
REQ-033 RD_WAIT=4 build, read 0x7FF -> _ram_oe low exactly 4 cycles, rsp_valid 4 cycles after accept; ram_addr stable throughout.
REQ-034 _reset low during WR_PULSE of write 0xFF@0x010 -> controls 1 next edge, no rsp_valid, req_ready=1 one edge after release.
REQ-035 Assertion across all tests: never (_ram_oe==0 && _ram_w==0); ram_addr/ram_wdata constant while _ram_cs==0.

Source files
------------

// File: rtl/main_ram_ctrl_pkg.sv
// main_ram_ctrl_pkg
//   Shared definitions for the asynchronous SRAM controller:
//   - state_t      : FSM state encoding (also visible on the debug port)
//   - CNT_W        : phase counter width
//   - DEF_*        : default phase lengths in clock cycles
//   - phase_load() : value loaded into the phase counter on phase entry
package main_ram_ctrl_pkg;

   localparam int CNT_W = 4;

   localparam int DEF_RD_WAIT  = 2;
   localparam int DEF_WR_SETUP = 1;
   localparam int DEF_WR_PULSE = 2;
   localparam int DEF_WR_HOLD  = 1;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RD_ACTIVE = 3'd1,
      ST_WR_SETUP  = 3'd2,
      ST_WR_PULSE  = 3'd3,
      ST_WR_HOLD   = 3'd4
   } state_t;

   // A phase of N cycles counts N-1 down to 0; the edge seen with the
   // counter at 0 is the last edge of the phase.
   function automatic logic [CNT_W-1:0] phase_load(input int unsigned len);
      return CNT_W'(len - 1);
   endfunction

endpackage

// File: rtl/main_ram_ctrl_phase_timer.sv
// ram_phase_timer
//   4-bit down counter timing one FSM phase. Loads on phase entry, then
//   decrements once per clock and sticks at zero (never wraps).
//   Ports:
//     i_clk      : clock, rising edge
//     i_rst_n    : synchronous active-low reset (count -> 0)
//     i_load     : load i_load_val this edge (takes priority over decrement)
//     i_load_val : phase length minus one
//     o_zero     : counter is zero (current phase ends on this edge)
module ram_phase_timer
   import main_ram_ctrl_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   output logic             o_zero
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (r_count != '0) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/main_ram_ctrl.sv
// main_ram_ctrl
//   Single-request host port to an asynchronous SRAM with programmable
//   read wait and write setup/pulse/hold lengths. Every output is a register.
//   Ports:
//     clk, _reset              : clock; synchronous active-low reset
//     req_valid/req_ready      : request handshake; a request transfers on a
//                                rising edge where both are 1. req_ready is
//                                1 only in IDLE; req_write/req_addr/req_wdata
//                                are only looked at on that edge.
//     rsp_valid, rsp_rdata     : one-cycle completion pulse, last read data
//     _ram_cs/_ram_oe/_ram_w   : active-low SRAM controls
//     ram_addr, ram_wdata      : address/data latched at accept
//     ram_rdata                : SRAM read data
//     o_dbg_state              : current FSM state (state_t encoding)
module main_ram_ctrl
   import main_ram_ctrl_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int ADDR_WIDTH = 20,
   parameter int RD_WAIT    = DEF_RD_WAIT,   // 1..15
   parameter int WR_SETUP   = DEF_WR_SETUP,  // 1..15
   parameter int WR_PULSE   = DEF_WR_PULSE,  // 1..15
   parameter int WR_HOLD    = DEF_WR_HOLD    // 1..15
) (
   input  logic                  clk,
   input  logic                  _reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [WIDTH-1:0]      req_wdata,
   output logic                  rsp_valid,
   output logic [WIDTH-1:0]      rsp_rdata,
   output logic                  _ram_cs,
   output logic                  _ram_oe,
   output logic                  _ram_w,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [WIDTH-1:0]      ram_wdata,
   input  logic [WIDTH-1:0]      ram_rdata,
   output logic [2:0]            o_dbg_state
);

   state_t                r_state, w_state_nxt;
   logic                  r_cs_n, r_oe_n, r_w_n, r_ready, r_rsp_valid;
   logic                  w_cs_n, w_oe_n, w_w_n, w_ready, w_rsp_valid;
   logic [WIDTH-1:0]      r_rdata, w_rdata_nxt;
   logic [WIDTH-1:0]      r_wdata, w_wdata_nxt;
   logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
   logic                  w_load, w_zero;
   logic [CNT_W-1:0]      w_load_val;

   ram_phase_timer u_timer (
      .i_clk      (clk),
      .i_rst_n    (_reset),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .o_zero     (w_zero)
   );

   // Next state and next value of every registered output. Controls
   // default to deasserted so any exit from a phase releases them.
   always_comb begin
      w_state_nxt = r_state;
      w_cs_n      = 1'b1;
      w_oe_n      = 1'b1;
      w_w_n       = 1'b1;
      w_ready     = 1'b0;
      w_rsp_valid = 1'b0;
      w_rdata_nxt = r_rdata;
      w_addr_nxt  = r_addr;
      w_wdata_nxt = r_wdata;
      w_load      = 1'b0;
      w_load_val  = '0;
      case (r_state)
         ST_IDLE: begin
            if (req_valid && r_ready) begin
               w_addr_nxt  = req_addr;
               w_wdata_nxt = req_wdata;
               w_cs_n      = 1'b0;
               w_load      = 1'b1;
               if (req_write) begin
                  w_state_nxt = ST_WR_SETUP;
                  w_load_val  = phase_load(WR_SETUP);
               end else begin
                  w_state_nxt = ST_RD_ACTIVE;
                  w_oe_n      = 1'b0;
                  w_load_val  = phase_load(RD_WAIT);
               end
            end else begin
               w_ready = 1'b1;
            end
         end
         ST_RD_ACTIVE: begin
            if (w_zero) begin
               // Last edge of the read window: data is still driven.
               w_state_nxt = ST_IDLE;
               w_rdata_nxt = ram_rdata;
               w_rsp_valid = 1'b1;
               w_ready     = 1'b1;
            end else begin
               w_cs_n = 1'b0;
               w_oe_n = 1'b0;
            end
         end
         ST_WR_SETUP: begin
            w_cs_n = 1'b0;
            if (w_zero) begin
               w_state_nxt = ST_WR_PULSE;
               w_w_n       = 1'b0;
               w_load      = 1'b1;
               w_load_val  = phase_load(WR_PULSE);
            end
         end
         ST_WR_PULSE: begin
            w_cs_n = 1'b0;
            if (w_zero) begin
               w_state_nxt = ST_WR_HOLD;
               w_load      = 1'b1;
               w_load_val  = phase_load(WR_HOLD);
            end else begin
               w_w_n = 1'b0;
            end
         end
         ST_WR_HOLD: begin
            if (w_zero) begin
               w_state_nxt = ST_IDLE;
               w_rsp_valid = 1'b1;
               w_ready     = 1'b1;
            end else begin
               w_cs_n = 1'b0;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!_reset) begin
         r_state     <= ST_IDLE;
         r_cs_n      <= 1'b1;
         r_oe_n      <= 1'b1;
         r_w_n       <= 1'b1;
         r_ready     <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rdata     <= '0;
         r_addr      <= '0;
         r_wdata     <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_cs_n      <= w_cs_n;
         r_oe_n      <= w_oe_n;
         r_w_n       <= w_w_n;
         r_ready     <= w_ready;
         r_rsp_valid <= w_rsp_valid;
         r_rdata     <= w_rdata_nxt;
         r_addr      <= w_addr_nxt;
         r_wdata     <= w_wdata_nxt;
      end
   end

   assign req_ready   = r_ready;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_rdata   = r_rdata;
   assign _ram_cs     = r_cs_n;
   assign _ram_oe     = r_oe_n;
   assign _ram_w      = r_w_n;
   assign ram_addr    = r_addr;
   assign ram_wdata   = r_wdata;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_main_ram_ctrl.sv
// tb_main_ram_ctrl
//   Directed bench for main_ram_ctrl: default-timing instance u_dut and an
//   RD_WAIT=4 instance u_dut4, each with a behavioural async SRAM.
module tb_main_ram_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   // default-timing instance
   logic        req_valid, req_ready, req_write, rsp_valid;
   logic [19:0] req_addr, ram_addr;
   logic [7:0]  req_wdata, rsp_rdata, ram_wdata, ram_rdata;
   logic        ram_cs_n, ram_oe_n, ram_w_n;
   logic [2:0]  dbg_state;

   // RD_WAIT=4 instance
   logic        b_req_valid, b_req_ready, b_req_write, b_rsp_valid;
   logic [19:0] b_req_addr, b_ram_addr;
   logic [7:0]  b_req_wdata, b_rsp_rdata, b_ram_wdata, b_ram_rdata;
   logic        b_ram_cs_n, b_ram_oe_n, b_ram_w_n;
   logic [2:0]  b_dbg_state;

   main_ram_ctrl u_dut (
      .clk(clk), ._reset(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      ._ram_cs(ram_cs_n), ._ram_oe(ram_oe_n), ._ram_w(ram_w_n),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .o_dbg_state(dbg_state)
   );

   main_ram_ctrl #(.RD_WAIT(4)) u_dut4 (
      .clk(clk), ._reset(rst_n),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
      .req_addr(b_req_addr), .req_wdata(b_req_wdata),
      .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
      ._ram_cs(b_ram_cs_n), ._ram_oe(b_ram_oe_n), ._ram_w(b_ram_w_n),
      .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata),
      .o_dbg_state(b_dbg_state)
   );

   // behavioural async SRAMs: write on rising _ram_w with _ram_cs low,
   // read data driven while _ram_cs and _ram_oe are both low
   logic [7:0] mem_a [0:4095];
   logic [7:0] mem_b [0:4095];

   initial begin
      for (int i = 0; i < 4096; i++) begin
         mem_a[i] = 8'h00;
         mem_b[i] = 8'h00;
      end
      mem_b[12'h7FF] = 8'hC3;
   end

   always @(posedge ram_w_n)   if (!ram_cs_n)   mem_a[ram_addr[11:0]]   = ram_wdata;
   always @(posedge b_ram_w_n) if (!b_ram_cs_n) mem_b[b_ram_addr[11:0]] = b_ram_wdata;

   assign ram_rdata   = (!ram_cs_n && !ram_oe_n)     ? mem_a[ram_addr[11:0]]   : 8'h00;
   assign b_ram_rdata = (!b_ram_cs_n && !b_ram_oe_n) ? mem_b[b_ram_addr[11:0]] : 8'h00;

   // scoreboard counters
   int n_checks = 0;
   int n_pass   = 0;
   int rsp_count = 0;
   logic mon_en = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   // continuous protocol checks on both instances
   logic        prev_cs_n, b_prev_cs_n;
   logic [19:0] prev_addr, b_prev_addr;
   logic [7:0]  prev_wdata, b_prev_wdata;

   always @(negedge clk) begin
      if (mon_en) begin
         check("mon_oe_w_overlap", {31'd0, (!ram_oe_n && !ram_w_n)}, 32'd0);
         check("mon4_oe_w_overlap", {31'd0, (!b_ram_oe_n && !b_ram_w_n)}, 32'd0);
         if (!prev_cs_n && !ram_cs_n) begin
            check("mon_addr_stable", {12'd0, ram_addr}, {12'd0, prev_addr});
            check("mon_wdata_stable", {24'd0, ram_wdata}, {24'd0, prev_wdata});
         end
         if (!b_prev_cs_n && !b_ram_cs_n) begin
            check("mon4_addr_stable", {12'd0, b_ram_addr}, {12'd0, b_prev_addr});
            check("mon4_wdata_stable", {24'd0, b_ram_wdata}, {24'd0, b_prev_wdata});
         end
         if (rsp_valid) rsp_count++;
      end
      prev_cs_n    = ram_cs_n;
      prev_addr    = ram_addr;
      prev_wdata   = ram_wdata;
      b_prev_cs_n  = b_ram_cs_n;
      b_prev_addr  = b_ram_addr;
      b_prev_wdata = b_ram_wdata;
   end

   // one transaction on u_dut, started at a falling edge; latency is counted
   // in rising edges from the accept edge to the edge raising rsp_valid
   task automatic do_req(input logic wr, input logic [19:0] a, input logic [7:0] d,
                         output int lat, output int cs_cyc, output int w_cyc,
                         output int oe_cyc, output logic [7:0] rd);
      check("ready_before_accept", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
      @(negedge clk);
      req_valid = 1'b0;
      lat = -1; cs_cyc = 0; w_cyc = 0; oe_cyc = 0; rd = '0;
      for (int i = 1; i <= 20; i++) begin
         if (rsp_valid) begin
            lat = i - 1;
            rd  = rsp_rdata;
            break;
         end
         if (!ram_cs_n) cs_cyc++;
         if (!ram_w_n)  w_cyc++;
         if (!ram_oe_n) oe_cyc++;
         @(negedge clk);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: observed=timeout expected=finish");
      $fatal(1, "simulation timeout");
   end

   int lat, cs_cyc, w_cyc, oe_cyc, got, rsp_before;
   logic [7:0] rd;
   logic addr_ok;

   initial begin
      rst_n = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0;

      // reset state
      repeat (2) @(negedge clk);
      check("rst_controls", {29'd0, ram_cs_n, ram_oe_n, ram_w_n}, 32'd7);
      check("rst_ready", {31'd0, req_ready}, 32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
      check("rst_ram_addr", {12'd0, ram_addr}, 32'd0);
      check("rst_ram_wdata", {24'd0, ram_wdata}, 32'd0);
      check("rst_state", {29'd0, dbg_state}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_first_edge", {31'd0, req_ready}, 32'd1);
      mon_en = 1'b1;

      // idle 5 cycles
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("idle_controls", {29'd0, ram_cs_n, ram_oe_n, ram_w_n}, 32'd7);
         check("idle_ready", {31'd0, req_ready}, 32'd1);
      end
      check("idle_no_rsp", rsp_count, 32'd0);

      // write 0x5A @ 0x00123
      do_req(1'b1, 20'h00123, 8'h5A, lat, cs_cyc, w_cyc, oe_cyc, rd);
      check("wr_latency", lat, 32'd4);
      check("wr_cs_cycles", cs_cyc, 32'd4);
      check("wr_w_cycles", w_cyc, 32'd2);
      check("wr_oe_cycles", oe_cyc, 32'd0);
      check("wr_rdata_untouched", {24'd0, rd}, 32'd0);
      @(negedge clk);
      check("wr_rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
      check("idle_addr_held", {12'd0, ram_addr}, 32'h00123);
      check("idle_wdata_held", {24'd0, ram_wdata}, 32'h5A);
      check("sram_written", {24'd0, mem_a[12'h123]}, 32'h5A);

      // read 0x00123
      do_req(1'b0, 20'h00123, 8'h00, lat, cs_cyc, w_cyc, oe_cyc, rd);
      check("rd_latency", lat, 32'd2);
      check("rd_oe_cycles", oe_cyc, 32'd2);
      check("rd_cs_cycles", cs_cyc, 32'd2);
      check("rd_w_cycles", w_cyc, 32'd0);
      check("rd_data", {24'd0, rd}, 32'h5A);
      @(negedge clk);
      check("rd_rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
      check("rd_data_held", {24'd0, rsp_rdata}, 32'h5A);

      // back-to-back writes with req_valid held high
      req_valid = 1'b1; req_write = 1'b1; req_addr = 20'h00001; req_wdata = 8'h11;
      @(negedge clk);
      req_addr = 20'h00002; req_wdata = 8'h22;
      got = 0;
      for (int i = 0; i < 20; i++) begin
         if (rsp_valid) begin
            got = 1;
            break;
         end
         @(negedge clk);
      end
      check("b2b_first_rsp", got, 32'd1);
      check("b2b_ready_with_rsp", {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      check("b2b_second_accepted", {29'd0, dbg_state}, 32'd2);
      check("b2b_second_cs", {31'd0, ram_cs_n}, 32'd0);
      check("b2b_second_addr", {12'd0, ram_addr}, 32'h2);
      check("b2b_second_wdata", {24'd0, ram_wdata}, 32'h22);
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         if (rsp_valid) begin
            lat = i - 1;
            break;
         end
         @(negedge clk);
      end
      check("b2b_second_latency", lat, 32'd4);
      check("b2b_rdata_kept", {24'd0, rsp_rdata}, 32'h5A);
      @(negedge clk);
      do_req(1'b0, 20'h00001, 8'h00, lat, cs_cyc, w_cyc, oe_cyc, rd);
      check("b2b_readback_1", {24'd0, rd}, 32'h11);
      @(negedge clk);
      do_req(1'b0, 20'h00002, 8'h00, lat, cs_cyc, w_cyc, oe_cyc, rd);
      check("b2b_readback_2", {24'd0, rd}, 32'h22);
      @(negedge clk);
      check("rsp_total", rsp_count, 32'd6);

      // reset during WR_PULSE of write 0xFF @ 0x010
      req_valid = 1'b1; req_write = 1'b1; req_addr = 20'h00010; req_wdata = 8'hFF;
      @(negedge clk);
      req_valid = 1'b0;
      got = 0;
      for (int i = 0; i < 10; i++) begin
         if (!ram_w_n) begin
            got = 1;
            break;
         end
         @(negedge clk);
      end
      check("abort_reached_pulse", got, 32'd1);
      rsp_before = rsp_count;
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_controls", {29'd0, ram_cs_n, ram_oe_n, ram_w_n}, 32'd7);
      check("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
      check("abort_ready", {31'd0, req_ready}, 32'd0);
      check("abort_state", {29'd0, dbg_state}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_ready_release", {31'd0, req_ready}, 32'd1);
      check("abort_rsp_release", {31'd0, rsp_valid}, 32'd0);
      repeat (4) @(negedge clk);
      check("abort_rsp_count", rsp_count, rsp_before);

      // RD_WAIT=4 instance: read 0x7FF
      check("rw4_ready", {31'd0, b_req_ready}, 32'd1);
      b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 20'h007FF;
      @(negedge clk);
      b_req_valid = 1'b0;
      lat = -1; oe_cyc = 0; addr_ok = 1'b1; rd = '0;
      for (int i = 1; i <= 20; i++) begin
         if (b_rsp_valid) begin
            lat = i - 1;
            rd  = b_rsp_rdata;
            break;
         end
         if (!b_ram_oe_n) oe_cyc++;
         if (b_ram_addr !== 20'h007FF) addr_ok = 1'b0;
         @(negedge clk);
      end
      check("rw4_latency", lat, 32'd4);
      check("rw4_oe_cycles", oe_cyc, 32'd4);
      check("rw4_addr_stable", {31'd0, addr_ok}, 32'd1);
      check("rw4_data", {24'd0, rd}, 32'hC3);
      @(negedge clk);
      check("rw4_rsp_one_cycle", {31'd0, b_rsp_valid}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
